alu_sequencer: RTL and testbench

//  Issue-side partner of the ALU. Collects one or two operands from the operand bus via valid/ready,

---
 rtl/alu_sequencer_if.sv | 50 +++++
 rtl/alu_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - ALU op/flag types and the sequencer bus interface
package alu_seq_pkg;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR,
        OP_NOT, OP_SHL, OP_SHR, OP_ROL, OP_ROR
    } alu_op_e;

    typedef enum logic [1:0] {
        FLAG_NONE, FLAG_ZERO, FLAG_CARRY, FLAG_REMAINDER
    } alu_flag_e;
endpackage

interface alu_sequencer_if #(
    parameter int WIDTH = 8
);
    import alu_seq_pkg::*;

    logic             start;
    alu_op_e          op_in;
    logic             chain_in;
    logic [WIDTH-1:0] operand_in;
    logic             operand_valid;
    logic             operand_ready;
    alu_op_e          alu_op;
    logic [WIDTH-1:0] alu_reg1;
    logic [WIDTH-1:0] alu_reg2;
    logic             alu_enable;
    logic [WIDTH-1:0] alu_result;
    alu_flag_e        alu_flag;
    logic             busy;
    logic [WIDTH-1:0] result;
    alu_flag_e        flag;
    logic             div_by_zero;
    logic             result_valid;
    logic             result_ready;

    modport slave (
        input  start, op_in, chain_in, operand_in, operand_valid,
        input  alu_result, alu_flag, result_ready,
        output operand_ready, alu_op, alu_reg1, alu_reg2, alu_enable,
        output busy, result, flag, div_by_zero, result_valid
    );

    modport master (
        output start, op_in, chain_in, operand_in, operand_valid,
        output alu_result, alu_flag, result_ready,
        input  operand_ready, alu_op, alu_reg1, alu_reg2, alu_enable,
        input  busy, result, flag, div_by_zero, result_valid
    );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - collects operands, drives a registered ALU, returns result/flag
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] DIV0_RESULT = 8'hFF,
    parameter bit               CHAIN_EN    = 1'b1
) (
    input logic            clock,
    input logic            reset_n,
    alu_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_CAPTURE, S_DONE
    } state_e;

    function automatic logic is_unary(input alu_op_e op);
        return op inside {OP_SHL, OP_ROL, OP_SHR, OP_ROR, OP_NOT};
    endfunction

    state_e           r_state;
    alu_op_e          r_op;
    logic [WIDTH-1:0] r_a;
    logic             r_have_result;
    logic [WIDTH-1:0] r_result;
    alu_flag_e        r_flag;
    logic             r_div0;
    alu_op_e          r_alu_op;
    logic [WIDTH-1:0] r_alu_reg1;
    logic [WIDTH-1:0] r_alu_reg2;

    state_e           w_next;
    alu_op_e          w_op_cur;
    logic             w_load_a;
    logic [WIDTH-1:0] w_a_d;
    logic             w_load_alu;
    logic [WIDTH-1:0] w_reg1_d;
    logic [WIDTH-1:0] w_reg2_d;
    logic             w_div0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // In IDLE the op is not latched yet, so decisions use op_in directly.
    always_comb begin
        w_next     = r_state;
        w_op_cur   = (r_state == S_IDLE) ? bus.op_in : r_op;
        w_load_a   = 1'b0;
        w_a_d      = r_a;
        w_load_alu = 1'b0;
        w_reg1_d   = r_a;
        w_reg2_d   = '0;
        w_div0     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (CHAIN_EN && bus.chain_in && r_have_result) begin
                        w_load_a = 1'b1;
                        w_a_d    = r_result;
                        if (is_unary(bus.op_in)) begin
                            w_next     = S_EXEC;
                            w_load_alu = 1'b1;
                            w_reg1_d   = r_result;
                        end else begin
                            w_next = S_LOAD_B;
                        end
                    end else begin
                        w_next = S_LOAD_A;
                    end
                end
            end
            S_LOAD_A: begin
                if (bus.operand_valid) begin
                    w_load_a = 1'b1;
                    w_a_d    = bus.operand_in;
                    if (is_unary(r_op)) begin
                        w_next     = S_EXEC;
                        w_load_alu = 1'b1;
                        w_reg1_d   = bus.operand_in;
                    end else begin
                        w_next = S_LOAD_B;
                    end
                end
            end
            S_LOAD_B: begin
                if (bus.operand_valid) begin
                    if (r_op == OP_DIV && bus.operand_in == '0) begin
                        w_div0 = 1'b1;
                        w_next = S_DONE;
                    end else begin
                        w_next     = S_EXEC;
                        w_load_alu = 1'b1;
                        w_reg2_d   = bus.operand_in;
                    end
                end
            end
            S_EXEC:    w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_DONE;
            S_DONE: begin
                if (bus.result_ready) begin
                    w_next = S_IDLE;
                end
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op          <= OP_ADD;
            r_a           <= '0;
            r_have_result <= 1'b0;
            r_result      <= '0;
            r_flag        <= FLAG_NONE;
            r_div0        <= 1'b0;
            r_alu_op      <= OP_ADD;
            r_alu_reg1    <= '0;
            r_alu_reg2    <= '0;
        end else begin
            if (r_state == S_IDLE && bus.start) begin
                r_op <= bus.op_in;
            end
            if (w_load_a) begin
                r_a <= w_a_d;
            end
            if (w_load_alu) begin
                r_alu_op   <= w_op_cur;
                r_alu_reg1 <= w_reg1_d;
                r_alu_reg2 <= w_reg2_d;
            end
            // A div-by-zero completion leaves have_result untouched.
            if (w_div0) begin
                r_result <= DIV0_RESULT;
                r_flag   <= FLAG_NONE;
                r_div0   <= 1'b1;
            end
            if (r_state == S_CAPTURE) begin
                r_result      <= bus.alu_result;
                r_flag        <= bus.alu_flag;
                r_div0        <= 1'b0;
                r_have_result <= 1'b1;
            end
        end
    end

    assign bus.operand_ready = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign bus.alu_enable    = (r_state == S_CAPTURE);
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.result_valid  = (r_state == S_DONE);
    assign bus.div_by_zero   = r_div0 && (r_state == S_DONE);
    assign bus.result        = r_result;
    assign bus.flag          = r_flag;
    assign bus.alu_op        = r_alu_op;
    assign bus.alu_reg1      = r_alu_reg1;
    assign bus.alu_reg2      = r_alu_reg2;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with a registered ALU model
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    typedef struct {
        bit        sel;
        alu_op_e   op;
        bit        chain;
        int        nops;
        logic [7:0] a;
        logic [7:0] b;
        int        gap;
        logic [7:0] res;
        alu_flag_e flg;
        bit        dz;
        int        lat;
        int        en;
        int        rdly;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        int         gap;
    } opnd_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    alu_op_e    op_in;
    logic       chain_in;
    logic [7:0] operand_in;
    logic       operand_valid;
    logic       result_ready;
    logic       sel;

    always #5 clock = ~clock;

    alu_sequencer_if #(.WIDTH(8)) bus0 ();
    alu_sequencer_if #(.WIDTH(8)) bus1 ();

    alu_sequencer #(.WIDTH(8), .DIV0_RESULT(8'hFF), .CHAIN_EN(1'b1)) dut0 (
        .clock(clock), .reset_n(reset_n), .bus(bus0));
    alu_sequencer #(.WIDTH(8), .DIV0_RESULT(8'hFF), .CHAIN_EN(1'b0)) dut1 (
        .clock(clock), .reset_n(reset_n), .bus(bus1));

    function automatic logic [8:0] calc(input alu_op_e op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_MUL:  return {1'b0, a * b};
            OP_DIV:  return (b == 8'd0) ? 9'd0 : {1'b0, a / b};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_NOT:  return {1'b0, ~a};
            OP_SHL:  return {1'b0, a[6:0], 1'b0};
            OP_SHR:  return {1'b0, 1'b0, a[7:1]};
            OP_ROL:  return {1'b0, a[6:0], a[7]};
            default: return {1'b0, a[0], a[7:1]};
        endcase
    endfunction

    function automatic alu_flag_e flag_of(input alu_op_e op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] c;
        c = calc(op, a, b);
        if (op == OP_DIV && b != 8'd0 && (a % b) != 8'd0) return FLAG_REMAINDER;
        if (c[8]) return FLAG_CARRY;
        if (c[7:0] == 8'd0) return FLAG_ZERO;
        return FLAG_NONE;
    endfunction

    logic [8:0] w_c0, w_c1;
    logic [7:0] tmp0, tmp1;
    assign w_c0 = calc(bus0.alu_op, bus0.alu_reg1, bus0.alu_reg2);
    assign w_c1 = calc(bus1.alu_op, bus1.alu_reg1, bus1.alu_reg2);
    always @(posedge clock) begin
        tmp0 <= w_c0[7:0];
        tmp1 <= w_c1[7:0];
    end

    assign bus0.start = start & ~sel;
    assign bus1.start = start & sel;
    assign bus0.op_in = op_in;
    assign bus1.op_in = op_in;
    assign bus0.chain_in = chain_in;
    assign bus1.chain_in = chain_in;
    assign bus0.operand_in = operand_in;
    assign bus1.operand_in = operand_in;
    assign bus0.operand_valid = operand_valid;
    assign bus1.operand_valid = operand_valid;
    assign bus0.result_ready = result_ready;
    assign bus1.result_ready = result_ready;
    assign bus0.alu_result = tmp0;
    assign bus1.alu_result = tmp1;
    assign bus0.alu_flag = flag_of(bus0.alu_op, bus0.alu_reg1, bus0.alu_reg2);
    assign bus1.alu_flag = flag_of(bus1.alu_op, bus1.alu_reg1, bus1.alu_reg2);

    logic       s_ready, s_valid, s_en, s_busy, s_dz;
    logic [7:0] s_reg2, s_result;
    alu_flag_e  s_flag;
    assign s_ready  = sel ? bus1.operand_ready : bus0.operand_ready;
    assign s_valid  = sel ? bus1.result_valid  : bus0.result_valid;
    assign s_en     = sel ? bus1.alu_enable    : bus0.alu_enable;
    assign s_busy   = sel ? bus1.busy          : bus0.busy;
    assign s_dz     = sel ? bus1.div_by_zero   : bus0.div_by_zero;
    assign s_reg2   = sel ? bus1.alu_reg2      : bus0.alu_reg2;
    assign s_result = sel ? bus1.result        : bus0.result;
    assign s_flag   = sel ? bus1.flag          : bus0.flag;

    int    n_vec = 0;
    int    n_mis = 0;
    int    cyc = 0;
    int    start_cyc, n_xfer, en_cnt, stall_seen, done_cnt;
    bit    in_done, cur_unary;
    vec_t  cur, cur_exp;
    vec_t  sb[$];
    vec_t  vecs[$];
    opnd_t opq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic present();
        if (opq.size() > 0 && opq[0].gap > 0) begin
            operand_valid = 1'b0;
            opq[0].gap = opq[0].gap - 1;
        end else if (opq.size() > 0) begin
            operand_valid = 1'b1;
            operand_in    = opq[0].d;
        end else begin
            operand_valid = 1'b0;
            operand_in    = 8'h00;
        end
    endtask

    task automatic tick();
        logic xfer;
        @(negedge clock);
        xfer = operand_valid && s_ready;
        if (s_en) begin
            en_cnt++;
            if (cur_unary) check("unary_reg2", s_reg2, 8'h00);
        end
        if (s_valid) begin
            if (!in_done) begin
                in_done = 1'b1;
                check("unexpected_result", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    cur_exp = sb.pop_front();
                    check("latency", cyc - start_cyc, cur_exp.lat);
                    check("transfers", n_xfer, cur_exp.nops);
                    check("enable_cycles", en_cnt, cur_exp.en);
                end
            end
            check("result", s_result, cur_exp.res);
            check("flag", s_flag, cur_exp.flg);
            check("div_by_zero", s_dz, cur_exp.dz);
            if (result_ready) begin
                in_done = 1'b0;
                done_cnt++;
            end else begin
                stall_seen++;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        if (xfer && opq.size() > 0) begin
            void'(opq.pop_front());
            n_xfer++;
        end
        present();
        result_ready = (stall_seen >= cur.rdly);
        start = (cur.rdly > 0) && (stall_seen == 1) && !result_ready;
    endtask

    task automatic launch(input vec_t v, input bit expect_out);
        cur       = v;
        cur_unary = v.op inside {OP_SHL, OP_ROL, OP_SHR, OP_ROR, OP_NOT};
        sel       = v.sel;
        op_in     = v.op;
        chain_in  = v.chain;
        opq.delete();
        if (v.nops >= 1) opq.push_back('{d: v.a, gap: 0});
        if (v.nops == 2) opq.push_back('{d: v.b, gap: v.gap});
        present();
        n_xfer       = 0;
        en_cnt       = 0;
        stall_seen   = 0;
        result_ready = (v.rdly == 0);
        start_cyc    = cyc;
        if (expect_out) sb.push_back(v);
        start = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int d0;
        int budget;
        d0 = done_cnt;
        budget = 40;
        launch(v, 1'b1);
        while (done_cnt == d0 && budget > 0) begin
            tick();
            budget--;
        end
        check("handshake_done", done_cnt != d0, 1);
        check("idle_after", s_busy, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, bus0.busy, 1'b0);
        check({tag, "_oready"}, bus0.operand_ready, 1'b0);
        check({tag, "_enable"}, bus0.alu_enable, 1'b0);
        check({tag, "_rvalid"}, bus0.result_valid, 1'b0);
        check({tag, "_dz"}, bus0.div_by_zero, 1'b0);
        check({tag, "_result"}, bus0.result, 8'h00);
        check({tag, "_reg1"}, bus0.alu_reg1, 8'h00);
        check({tag, "_reg2"}, bus0.alu_reg2, 8'h00);
        check({tag, "_aluop"}, bus0.alu_op, OP_ADD);
        check({tag, "_flag"}, bus0.flag, FLAG_NONE);
        check({tag, "_busy1"}, bus1.busy, 1'b0);
    endtask

    function automatic vec_t mk(input bit s, input alu_op_e op, input bit ch, input int nops,
                                input logic [7:0] a, input logic [7:0] b, input int gap,
                                input logic [7:0] res, input alu_flag_e flg, input bit dz,
                                input int lat, input int en, input int rdly);
        vec_t v;
        v = '{sel: s, op: op, chain: ch, nops: nops, a: a, b: b, gap: gap, res: res,
              flg: flg, dz: dz, lat: lat, en: en, rdly: rdly};
        return v;
    endfunction

    initial begin
        reset_n = 1'b0; start = 1'b0; op_in = OP_ADD; chain_in = 1'b0;
        operand_in = 8'h00; operand_valid = 1'b0; result_ready = 1'b1; sel = 1'b0;
        done_cnt = 0; in_done = 1'b0; cur_unary = 1'b0;
        cur = mk(0, OP_ADD, 0, 0, 0, 0, 0, 0, FLAG_NONE, 0, 0, 0, 0);
        cur_exp = cur;

        vecs.push_back(mk(0, OP_ADD, 0, 2, 8'h80, 8'h90, 0, 8'h10, FLAG_CARRY,     0, 5, 1, 0));
        vecs.push_back(mk(0, OP_DIV, 0, 2, 8'd7,  8'd2,  0, 8'd3,  FLAG_REMAINDER, 0, 5, 1, 0));
        vecs.push_back(mk(0, OP_DIV, 0, 2, 8'd9,  8'd0,  0, 8'hFF, FLAG_NONE,      1, 3, 0, 0));
        vecs.push_back(mk(0, OP_SHL, 1, 0, 8'd0,  8'd0,  0, 8'hFE, FLAG_NONE,      0, 3, 1, 0));
        vecs.push_back(mk(0, OP_NOT, 0, 1, 8'h0F, 8'd0,  0, 8'hF0, FLAG_NONE,      0, 4, 1, 0));
        vecs.push_back(mk(0, OP_ADD, 0, 2, 8'd3,  8'd4,  0, 8'd7,  FLAG_NONE,      0, 5, 1, 0));
        vecs.push_back(mk(0, OP_SUB, 1, 1, 8'd7,  8'd0,  0, 8'd0,  FLAG_ZERO,      0, 4, 1, 0));
        vecs.push_back(mk(1, OP_ADD, 0, 2, 8'd3,  8'd4,  0, 8'd7,  FLAG_NONE,      0, 5, 1, 0));
        vecs.push_back(mk(1, OP_SUB, 1, 2, 8'd7,  8'd7,  0, 8'd0,  FLAG_ZERO,      0, 5, 1, 0));
        vecs.push_back(mk(0, OP_ADD, 0, 2, 8'd1,  8'd2,  2, 8'd3,  FLAG_NONE,      0, 7, 1, 3));
        vecs.push_back(mk(0, OP_ROL, 1, 0, 8'd0,  8'd0,  0, 8'd6,  FLAG_NONE,      0, 3, 1, 0));

        repeat (3) @(posedge clock);
        #1;
        check_reset("reset");
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        launch(mk(0, OP_ADD, 0, 2, 8'd5, 8'd6, 0, 8'd11, FLAG_NONE, 0, 5, 1, 0), 1'b0);
        repeat (3) tick();
        #1;
        reset_n = 1'b0;
        #1;
        check_reset("midexec");
        opq.delete();
        present();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        run_vec(mk(0, OP_ADD, 1, 2, 8'd8, 8'd9, 0, 8'h11, FLAG_NONE, 0, 5, 1, 0));
        repeat (4) tick();
        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
